// File: rtl/rgen_arbiter_pkg.sv
// rtl/rgen_arbiter_pkg.sv - shared types and status codes for the two-requester host arbiter
// Contents:
//   arb_state_e         : one-hot arbiter state (IDLE, BUSY, DONE)
//   RGEN_STATUS_OKAY    : 3-bit status for a normal completion
//   RGEN_STATUS_TIMEOUT : 3-bit status for a forced completion after a stalled BUSY
package rgen_arbiter_pkg;

    // One-hot encoding; any other pattern decodes back to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        DONE = 3'b100
    } arb_state_e;

    localparam logic [2:0] RGEN_STATUS_OKAY    = 3'b000;
    localparam logic [2:0] RGEN_STATUS_TIMEOUT = 3'b010;

endpackage

// File: rtl/rgen_round_robin_2.sv
// rtl/rgen_round_robin_2.sv - two-way round-robin grant selector
// Ports:
//   i_request : per-requester request vector
//   i_pointer : requester favoured when both request
//   o_grant   : one-hot grant (all zero when nothing requests)
module rgen_round_robin_2 (
    input  logic [1:0] i_request,
    input  logic       i_pointer,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (&i_request) begin
            o_grant = i_pointer ? 2'b10 : 2'b01;
        end else begin
            // Zero or one bit set: already one-hot (or empty).
            o_grant = i_request;
        end
    end

endmodule

// File: rtl/rgen_host_arbiter.sv
// rtl/rgen_host_arbiter.sv - arbitrates two host requesters onto one local command bus
// Optional feature: define RGEN_HOST_ARBITER_TIMEOUT_EN to force an error completion
// after TIMEOUT_CYCLES cycles in BUSY without a downstream response.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   i_command_valid/i_write/i_read   : per-requester command request and type
//   i_address/i_write_data/i_write_mask : per-requester command payload
//   o_response_ready                 : per-requester one-cycle completion pulse
//   o_read_data/o_status             : shared response, non-zero only during a pulse
//   o_command_valid..o_write_mask    : downstream command bus, driven only in BUSY
//   i_response_ready/i_read_data/i_status : downstream response
module rgen_host_arbiter
    import rgen_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    i_command_valid,
    input  logic [1:0]                    i_write,
    input  logic [1:0]                    i_read,
    input  logic [1:0][ADDRESS_WIDTH-1:0] i_address,
    input  logic [1:0][DATA_WIDTH-1:0]    i_write_data,
    input  logic [1:0][DATA_WIDTH-1:0]    i_write_mask,
    output logic [1:0]                    o_response_ready,
    output logic [DATA_WIDTH-1:0]         o_read_data,
    output logic [2:0]                    o_status,
    output logic                          o_command_valid,
    output logic                          o_write,
    output logic                          o_read,
    output logic [ADDRESS_WIDTH-1:0]      o_address,
    output logic [DATA_WIDTH-1:0]         o_write_data,
    output logic [DATA_WIDTH-1:0]         o_write_mask,
    input  logic                          i_response_ready,
    input  logic [DATA_WIDTH-1:0]         i_read_data,
    input  logic [2:0]                    i_status
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e               state_q, state_d;
    logic                     ptr_q, ptr_d;
    logic                     grant_q, grant_d;
    logic                     write_q, write_d;
    logic                     read_q, read_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    wmask_q, wmask_d;

    logic [1:0] rr_grant;
    logic       rr_idx;
    logic       in_busy;
    logic       real_resp;
    logic       timeout_hit;
    logic       finish;

    rgen_round_robin_2 u_round_robin (
        .i_request (i_command_valid),
        .i_pointer (ptr_q),
        .o_grant   (rr_grant)
    );

    assign rr_idx    = rr_grant[1];
    assign in_busy   = (state_q == BUSY);
    assign real_resp = in_busy && i_response_ready;

`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A response arriving on the timeout cycle takes precedence.
    assign timeout_hit = in_busy && !i_response_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    assign finish = real_resp || timeout_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        write_d   = write_q;
        read_d    = read_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (|i_command_valid) begin
                    grant_d   = rr_idx;
                    write_d   = i_write[rr_idx];
                    read_d    = i_read[rr_idx];
                    address_d = i_address[rr_idx];
                    wdata_d   = i_write_data[rr_idx];
                    wmask_d   = i_write_mask[rr_idx];
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    ptr_d   = ~grant_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && |i_command_valid) begin
            cnt_d = '0;
        end else if (in_busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            read_q    <= read_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Outputs are qualified with rst_n so a reset cycle shows all zeros even
    // while the registers still hold BUSY, and a response during reset is dropped.
    always_comb begin
        o_command_valid  = 1'b0;
        o_write          = 1'b0;
        o_read           = 1'b0;
        o_address        = '0;
        o_write_data     = '0;
        o_write_mask     = '0;
        o_response_ready = 2'b00;
        o_read_data      = '0;
        o_status         = RGEN_STATUS_OKAY;
        if (rst_n && in_busy) begin
            o_command_valid = 1'b1;
            o_write         = write_q;
            o_read          = read_q;
            o_address       = address_q;
            o_write_data    = wdata_q;
            o_write_mask    = wmask_q;
        end
        if (rst_n && finish) begin
            o_response_ready = grant_q ? 2'b10 : 2'b01;
            if (real_resp) begin
                o_read_data = i_read_data;
                o_status    = i_status;
            end else begin
                o_status    = RGEN_STATUS_TIMEOUT;
            end
        end
    end

endmodule

// File: doc/rgen_host_arbiter.md
RGEN_HOST_ARBITER -- requirements
Module: rgen_host_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data, mask and read-data buses.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8: width of the local byte address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY cycles allowed before a forced error response (timeout build only).
REQ-004 SHALL have clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_n  in  1: reset, synchronous and active-low.
REQ-006 SHALL have i_command_valid  in  [2]: per-requester command request.
REQ-007 SHALL have i_write, i_read  in  [2]: per-requester access type.
REQ-008 SHALL have i_address  in  [2][ADDRESS_WIDTH]: per-requester address.
REQ-009 SHALL have i_write_data, i_write_mask  in  [2][DATA_WIDTH]: per-requester write payload.
REQ-010 SHALL have o_response_ready  out  [2]: per-requester one-cycle completion pulse.
REQ-011 SHALL have o_read_data  out  DATA_WIDTH, and o_status  out  3: response shared by both requesters, valid only with o_response_ready.
REQ-012 SHALL have o_command_valid, o_write, o_read  out  1 each; o_address  out  ADDRESS_WIDTH; o_write_data, o_write_mask  out  DATA_WIDTH: the downstream local command bus.
REQ-013 SHALL have i_response_ready  in  1; i_read_data  in  DATA_WIDTH; i_status  in  3: the downstream response.

Function
REQ-014 SHALL implement the states IDLE, BUSY and DONE, with one-hot-safe decoding.
REQ-015 In IDLE with any i_command_valid high, SHALL grant one requester, latch its write, read, address, data and mask, and enter BUSY on the next edge.
REQ-016 SHALL grant the requester selected by the round-robin pointer when both request; a lone requester is granted regardless of the pointer.
REQ-017 In BUSY, SHALL drive o_command_valid=1 and the latched command; the command stays stable until the state leaves BUSY.
REQ-018 SHALL take exactly 1 cycle from request sampled in IDLE to o_command_valid high.
REQ-019 On i_response_ready in BUSY, SHALL in the same cycle pulse o_response_ready[grant], pass i_read_data and i_status to o_read_data and o_status, and enter DONE.
REQ-020 On completion, SHALL set the pointer to the non-granted requester.
REQ-021 In DONE, SHALL hold o_command_valid=0, ignore all requests for 1 cycle, then return to IDLE, so the requester can drop i_command_valid.
REQ-022 Outside a response pulse, SHALL drive o_read_data=0 and o_status=0.
REQ-023 SHALL ignore i_response_ready in IDLE and DONE.
REQ-024 SHALL ignore changes on a non-granted requester's inputs during BUSY; its request stays pending.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, pointer=0, and all latched command fields to 0.
REQ-026 During reset, all outputs SHALL be 0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the transaction with no o_response_ready pulse.

Configuration
REQ-028 With RGEN_HOST_ARBITER_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-029 With RGEN_HOST_ARBITER_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES with no i_response_ready, the block SHALL pulse o_response_ready[grant] with o_read_data=0 and o_status=RGEN_STATUS_TIMEOUT, and enter DONE.
REQ-030 If i_response_ready coincides with the timeout cycle, the real response SHALL win.
REQ-031 Without RGEN_HOST_ARBITER_TIMEOUT_EN, the block SHALL have no counter and no TIMEOUT_CYCLES logic, and BUSY SHALL wait indefinitely.

Structure
REQ-032 Package rgen_arbiter_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the 3-bit constants RGEN_STATUS_OKAY=3'b000 and RGEN_STATUS_TIMEOUT=3'b010.
REQ-033 SHALL contain one sub-module, rgen_round_robin_2, which takes the request vector and pointer and returns a one-hot grant.

Verification
REQ-034 Single request: requester 0 writes addr 8'h04, data 32'hDEADBEEF, mask all ones -> o_command_valid high 1 cycle later; i_response_ready gives o_response_ready[0] pulse; requester 1 never pulsed.
REQ-035 Both requesting after reset -> requester 0 served first, then requester 1 served after 1 DONE cycle; both requesting again -> requester 0 served next (pointer alternates).
REQ-036 Read response: i_read_data=32'h12345678, i_status=0 -> the o_response_ready[1] cycle shows exactly those values; all other cycles show 0.
REQ-037 Reset mid-BUSY: rst_n=0 for 1 cycle -> IDLE, o_command_valid=0, no response pulse, pointer=0.
REQ-038 TIMEOUT_EN build with TIMEOUT_CYCLES=4 and no i_response_ready -> error pulse with o_status=3'b010 and o_read_data=0; i_response_ready in the following DONE cycle is ignored.
REQ-039 Spurious i_response_ready in IDLE -> no o_response_ready pulse and no state change.
